data_memory_store_queue: RTL and testbench

Parametrised stage-4 store unit that accepts stores from the pipeline, aligns data and byte enables onto memory lanes, buffers them in a DEPTH-entry FIFO, and drains them to data memory over a req/ack handshake. Generalises the combinational store write interface:
- any XLEN (32/64);
- byte/half/word/dword sizes;
- misaligned stores split into two aligned beats, or trapped;
- back-pressure via ready;
- a load-hazard check against pending stores.

---
 rtl/store_queue_pkg.sv | 35 +++
 rtl/store_lane_align.sv | 53 +++++
 rtl/data_memory_store_queue.sv | 169 ++++++++++++++++
 tb/tb_data_memory_store_queue.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/store_queue_pkg.sv
// Shared types and helpers for the data-memory store queue and its lane aligner.
package store_queue_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'd0,
        SZ_HALF  = 2'd1,
        SZ_WORD  = 2'd2,
        SZ_DWORD = 2'd3
    } store_size_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2
    } drain_state_e;

    // Widest supported configuration. The queue keeps an XLEN-sized copy of this layout.
    localparam int SQ_XLEN = 64;
    localparam int SQ_NB   = SQ_XLEN / 8;

    typedef struct packed {
        logic [SQ_XLEN-1:0] addr;
        logic [SQ_XLEN-1:0] data_lo;
        logic [SQ_XLEN-1:0] data_hi;
        logic [SQ_NB-1:0]   be_lo;
        logic [SQ_NB-1:0]   be_hi;
        logic               hi_needed;
    } sq_entry_t;

    // Number of bytes written by a store of the given size.
    function automatic int size_bytes(store_size_e size);
        return 1 << size;
    endfunction

endpackage

// File: rtl/store_lane_align.sv
// Combinational lane aligner: places a right-justified value and its byte
// enables across two memory lanes and flags stores the queue cannot issue.
module store_lane_align
    import store_queue_pkg::*;
#(
    parameter int XLEN             = 32,
    parameter int ALLOW_MISALIGNED = 1
) (
    input  logic [XLEN-1:0]   addr,
    input  logic [XLEN-1:0]   data,
    input  logic [1:0]        size,
    output logic [XLEN-1:0]   line_addr,
    output logic [XLEN-1:0]   data_lo,
    output logic [XLEN-1:0]   data_hi,
    output logic [XLEN/8-1:0] be_lo,
    output logic [XLEN/8-1:0] be_hi,
    output logic              fault
);
    localparam int NB = XLEN / 8;
    localparam int OW = $clog2(NB);

    logic [OW-1:0]     off;
    int                off_i;
    int                nbytes;
    logic [2*NB-1:0]   mask;
    logic [2*NB-1:0]   be2;
    logic [2*XLEN-1:0] data2;

    // Shift data and enables by the byte offset, then zero lanes that are not written.
    always_comb begin
        off       = addr[OW-1:0];
        off_i     = int'(off);
        line_addr = addr & ~XLEN'(NB - 1);
        nbytes    = size_bytes(store_size_e'(size));
        for (int i = 0; i < 2 * NB; i++) begin
            mask[i] = (i < nbytes);
        end
        be2   = mask << off;
        data2 = {{XLEN{1'b0}}, data} << {off, 3'b000};
        for (int i = 0; i < 2 * NB; i++) begin
            if (!be2[i]) begin
                data2[8*i +: 8] = 8'h00;
            end
        end
        data_lo = data2[XLEN-1:0];
        data_hi = data2[2*XLEN-1:XLEN];
        be_lo   = be2[NB-1:0];
        be_hi   = be2[2*NB-1:NB];
        fault   = ((XLEN == 32) && (size == 2'd3)) ||
                  ((ALLOW_MISALIGNED == 0) && ((off_i & (nbytes - 1)) != 0));
    end

endmodule

// File: rtl/data_memory_store_queue.sv
// Store queue: aligns pipeline stores, buffers them in a FIFO and drains one
// beat at a time to data memory; split stores issue a second beat.
// Handshakes: a store transfers on an edge where st_valid && st_ready; a beat
// transfers on an edge where mem_req && mem_ack, and the beat stays stable until then.
module data_memory_store_queue
    import store_queue_pkg::*;
#(
    parameter int XLEN             = 32,
    parameter int DEPTH            = 4,
    parameter int ALLOW_MISALIGNED = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   st_valid,
    output logic                   st_ready,
    input  logic [XLEN-1:0]        st_addr,
    input  logic [XLEN-1:0]        st_data,
    input  logic [1:0]             st_size,
    output logic                   mem_req,
    input  logic                   mem_ack,
    output logic [XLEN-1:0]        mem_addr,
    output logic [XLEN-1:0]        mem_wdata,
    output logic [XLEN/8-1:0]      mem_be,
    input  logic                   ld_check_valid,
    input  logic [XLEN-1:0]        ld_check_addr,
    output logic                   ld_hazard,
    output logic                   misaligned_fault,
    output logic [$clog2(DEPTH):0] count,
    output logic [1:0]             dbg_state
);
    localparam int NB = XLEN / 8;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef struct packed {
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] data_lo;
        logic [XLEN-1:0] data_hi;
        logic [NB-1:0]   be_lo;
        logic [NB-1:0]   be_hi;
        logic            hi_needed;
    } entry_t;

    entry_t           mem_q [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    drain_state_e     state;
    entry_t           new_entry;
    entry_t           head;
    logic             fault;
    logic             push;
    logic             pop;
    logic [CW-1:0]    count_next;
    logic [XLEN-1:0]  ld_line;

    store_lane_align #(
        .XLEN             (XLEN),
        .ALLOW_MISALIGNED (ALLOW_MISALIGNED)
    ) u_align (
        .addr      (st_addr),
        .data      (st_data),
        .size      (st_size),
        .line_addr (new_entry.addr),
        .data_lo   (new_entry.data_lo),
        .data_hi   (new_entry.data_hi),
        .be_lo     (new_entry.be_lo),
        .be_hi     (new_entry.be_hi),
        .fault     (fault)
    );

    assign new_entry.hi_needed = |new_entry.be_hi;
    assign head       = mem_q[rd_ptr];
    assign st_ready   = (count < CW'(DEPTH));
    assign push       = st_valid && st_ready && !fault;
    assign pop        = mem_ack && (((state == ST_BEAT0) && !head.hi_needed) || (state == ST_BEAT1));
    assign count_next = count + CW'(push) - CW'(pop);
    assign dbg_state  = state;
    assign ld_line    = ld_check_addr & ~XLEN'(NB - 1);

    // Entry storage; contents need no reset because valid_q qualifies them.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr] <= new_entry;
        end
    end

    // Pointers, occupancy, valid bits and the one-cycle fault pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            count            <= '0;
            valid_q          <= '0;
            misaligned_fault <= 1'b0;
        end else begin
            misaligned_fault <= st_valid && st_ready && fault;
            if (push) begin
                valid_q[wr_ptr] <= 1'b1;
                wr_ptr          <= wr_ptr + PW'(1);
            end
            if (pop) begin
                valid_q[rd_ptr] <= 1'b0;
                rd_ptr          <= rd_ptr + PW'(1);
            end
            count <= count_next;
        end
    end

    // Drain FSM: start on a non-empty queue (or a store arriving), one beat per ack.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if ((count != '0) || push) begin
                        state <= ST_BEAT0;
                    end
                end
                ST_BEAT0: begin
                    if (mem_ack) begin
                        if (head.hi_needed) begin
                            state <= ST_BEAT1;
                        end else begin
                            state <= (count_next != '0) ? ST_BEAT0 : ST_IDLE;
                        end
                    end
                end
                ST_BEAT1: begin
                    if (mem_ack) begin
                        state <= (count_next != '0) ? ST_BEAT0 : ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Beat outputs come from the head entry, which cannot change until its final ack.
    always_comb begin
        mem_req   = (state != ST_IDLE);
        mem_addr  = '0;
        mem_wdata = '0;
        mem_be    = '0;
        if (state == ST_BEAT0) begin
            mem_addr  = head.addr;
            mem_wdata = head.data_lo;
            mem_be    = head.be_lo;
        end else if (state == ST_BEAT1) begin
            mem_addr  = head.addr + XLEN'(NB);
            mem_wdata = head.data_hi;
            mem_be    = head.be_hi;
        end
    end

    // Load hazard: the load's aligned address matches any pending beat address.
    always_comb begin
        ld_hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && ((mem_q[i].addr == ld_line) ||
                               (mem_q[i].hi_needed && ((mem_q[i].addr + XLEN'(NB)) == ld_line)))) begin
                ld_hazard = 1'b1;
            end
        end
        ld_hazard = ld_hazard && ld_check_valid;
    end

endmodule

// File: tb/tb_data_memory_store_queue.sv
// Directed bench for the store queue: an ALLOW_MISALIGNED=1 instance for the
// main traffic and an ALLOW_MISALIGNED=0 instance for the alignment fault.
module tb_data_memory_store_queue;

  logic        clk;
  logic        reset;
  logic        st_valid;
  logic        na_st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [1:0]  st_size;
  logic        mem_ack;
  logic        ld_check_valid;
  logic [31:0] ld_check_addr;

  logic        st_ready,  na_st_ready;
  logic        mem_req,   na_mem_req;
  logic [31:0] mem_addr,  na_mem_addr;
  logic [31:0] mem_wdata, na_mem_wdata;
  logic [3:0]  mem_be,    na_mem_be;
  logic        ld_hazard, na_ld_hazard;
  logic        misaligned_fault, na_misaligned_fault;
  logic [2:0]  count,     na_count;
  logic [1:0]  dbg_state, na_dbg_state;

  logic [67:0] exp_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  data_memory_store_queue #(.XLEN(32), .DEPTH(4), .ALLOW_MISALIGNED(1)) dut (
    .clk(clk), .reset(reset), .st_valid(st_valid), .st_ready(st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .ld_check_valid(ld_check_valid), .ld_check_addr(ld_check_addr),
    .ld_hazard(ld_hazard), .misaligned_fault(misaligned_fault),
    .count(count), .dbg_state(dbg_state)
  );

  data_memory_store_queue #(.XLEN(32), .DEPTH(4), .ALLOW_MISALIGNED(0)) dut_na (
    .clk(clk), .reset(reset), .st_valid(na_st_valid), .st_ready(na_st_ready),
    .st_addr(st_addr), .st_data(st_data), .st_size(st_size),
    .mem_req(na_mem_req), .mem_ack(mem_ack), .mem_addr(na_mem_addr),
    .mem_wdata(na_mem_wdata), .mem_be(na_mem_be),
    .ld_check_valid(ld_check_valid), .ld_check_addr(ld_check_addr),
    .ld_hazard(na_ld_hazard), .misaligned_fault(na_misaligned_fault),
    .count(na_count), .dbg_state(na_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [67:0] got, input logic [67:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // scoreboard: every accepted beat must match the head of exp_q
  always @(negedge clk) begin
    #3;
    if (!reset && mem_req && mem_ack) begin
      if (exp_q.size() == 0) check("beat_extra", 68'(exp_q.size()), 68'd1);
      else check("beat", {mem_addr, mem_be, mem_wdata}, exp_q.pop_front());
    end
  end

  // driver: present a store and hold it until it is accepted
  task automatic push_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    int t;
    t = 0;
    st_valid = 1'b1; st_addr = a; st_data = d; st_size = s;
    #1;
    while (!st_ready && t < 100) begin
      @(negedge clk); #1; t++;
    end
    if (!st_ready) check("push_timeout", 68'(st_ready), 68'd1);
    @(negedge clk);
    st_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    #1;
    while ((count != 3'd0 || mem_req) && t < 100) begin
      @(negedge clk); #1; t++;
    end
    check("drain_idle", {count, mem_req}, 4'b0000);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; st_valid = 1'b0; na_st_valid = 1'b0;
    st_addr = '0; st_data = '0; st_size = 2'd0; mem_ack = 1'b0;
    ld_check_valid = 1'b1; ld_check_addr = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_mem_req",  68'(mem_req), 68'd0);
    check("rst_count",    68'(count), 68'd0);
    check("rst_st_ready", 68'(st_ready), 68'd1);
    check("rst_fault",    68'(misaligned_fault), 68'd0);
    check("rst_hazard",   68'(ld_hazard), 68'd0);
    check("rst_beat",     {mem_addr, mem_be, mem_wdata}, 68'd0);
    check("rst_state",    68'(dbg_state), 68'd0);
    @(negedge clk);
    reset = 1'b0; ld_check_valid = 1'b0;
    @(negedge clk);

    // 1: aligned word, one-cycle latency to mem_req
    mem_ack = 1'b1;
    exp_q.push_back({32'h100, 4'b1111, 32'hDEADBEEF});
    push_store(32'h100, 32'hDEADBEEF, 2'd2);
    #1;
    check("sw_req",  68'(mem_req), 68'd1);
    check("sw_beat", {mem_addr, mem_be, mem_wdata}, {32'h100, 4'b1111, 32'hDEADBEEF});
    @(negedge clk); #1;
    check("sw_count", 68'(count), 68'd0);
    check("sw_idle",  68'(mem_req), 68'd0);
    @(negedge clk);

    // 2: byte store at lane 3, upper data bits must be dropped
    exp_q.push_back({32'h100, 4'b1000, 32'hAB000000});
    push_store(32'h103, 32'hFFFFFFAB, 2'd0);
    #1;
    check("sb_beat", {mem_addr, mem_be, mem_wdata}, {32'h100, 4'b1000, 32'hAB000000});
    wait_idle();

    // 3: misaligned word split into two beats, single pop
    exp_q.push_back({32'h100, 4'b1100, 32'h33440000});
    exp_q.push_back({32'h104, 4'b0011, 32'h00001122});
    push_store(32'h102, 32'h11223344, 2'd2);
    #1;
    check("split_beat0", {mem_addr, mem_be, mem_wdata}, {32'h100, 4'b1100, 32'h33440000});
    @(negedge clk); #1;
    check("split_beat1", {mem_addr, mem_be, mem_wdata}, {32'h104, 4'b0011, 32'h00001122});
    check("split_count", 68'(count), 68'd1);
    @(negedge clk); #1;
    check("split_popped", 68'(count), 68'd0);
    wait_idle();

    // 5: load hazard against a pending split store
    mem_ack = 1'b0;
    exp_q.push_back({32'h100, 4'b1100, 32'h33440000});
    exp_q.push_back({32'h104, 4'b0011, 32'h00001122});
    push_store(32'h102, 32'h11223344, 2'd2);
    ld_check_valid = 1'b1;
    ld_check_addr = 32'h106; #1;
    check("hz_beat1_addr", 68'(ld_hazard), 68'd1);
    ld_check_addr = 32'h108; #1;
    check("hz_miss", 68'(ld_hazard), 68'd0);
    ld_check_addr = 32'h101; #1;
    check("hz_beat0_addr", 68'(ld_hazard), 68'd1);
    ld_check_valid = 1'b0; #1;
    check("hz_not_valid", 68'(ld_hazard), 68'd0);
    ld_check_valid = 1'b1; ld_check_addr = 32'h106;
    @(negedge clk); mem_ack = 1'b1;
    @(negedge clk); mem_ack = 1'b0; #1;
    check("hz_after_beat0", 68'(ld_hazard), 68'd1);
    check("hz_in_beat1", 68'(mem_addr), 68'h104);
    @(negedge clk); mem_ack = 1'b1;
    @(negedge clk); mem_ack = 1'b0; #1;
    check("hz_cleared", 68'(ld_hazard), 68'd0);
    ld_check_valid = 1'b0;
    wait_idle();

    // 4: fill with ack low, fifth store held off, then drain in order
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({32'h200 + 32'(4 * i), 4'b1111, 32'hA0 + 32'(i)});
      push_store(32'h200 + 32'(4 * i), 32'hA0 + 32'(i), 2'd2);
    end
    #1;
    check("full_ready", 68'(st_ready), 68'd0);
    check("full_count", 68'(count), 68'd4);
    st_valid = 1'b1; st_addr = 32'h210; st_data = 32'hA4; st_size = 2'd2;
    repeat (3) begin
      @(negedge clk); #1;
      check("full_held", {count, st_ready}, {3'd4, 1'b0});
    end
    check("full_head", 68'(mem_addr), 68'h200);
    exp_q.push_back({32'h210, 4'b1111, 32'hA4});
    mem_ack = 1'b1;
    push_store(32'h210, 32'hA4, 2'd2);
    wait_idle();

    // 6a: misaligned half on the trapping instance, dword on the splitting one
    @(negedge clk);
    na_st_valid = 1'b1; st_addr = 32'h101; st_data = 32'h5555; st_size = 2'd1;
    @(negedge clk);
    na_st_valid = 1'b0; #1;
    check("na_fault_pulse", {na_misaligned_fault, na_mem_req, na_count}, {1'b1, 1'b0, 3'd0});
    @(negedge clk); #1;
    check("na_fault_clear", {na_misaligned_fault, na_mem_req, na_count}, {1'b0, 1'b0, 3'd0});
    st_valid = 1'b1; st_addr = 32'h100; st_size = 2'd3;
    @(negedge clk);
    st_valid = 1'b0; #1;
    check("dword_fault", {misaligned_fault, mem_req, count}, {1'b1, 1'b0, 3'd0});
    @(negedge clk); #1;
    check("dword_clear", 68'(misaligned_fault), 68'd0);

    // 6b: asynchronous reset with a beat in flight
    mem_ack = 1'b0;
    push_store(32'h300, 32'h12345678, 2'd2);
    push_store(32'h304, 32'h9ABCDEF0, 2'd2);
    #1;
    check("inflight_req", {mem_req, count}, {1'b1, 3'd2});
    reset = 1'b1; #1;
    check("async_rst_req", {mem_req, count}, {1'b0, 3'd0});
    ld_check_valid = 1'b1; ld_check_addr = 32'h300; #1;
    check("async_rst_hazard", 68'(ld_hazard), 68'd0);
    ld_check_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("post_rst_idle", {mem_req, count, st_ready}, {1'b0, 3'd0, 1'b1});
    check("sb_empty", 68'(exp_q.size()), 68'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
